serial_add_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in

---
 rtl/serial_add_ctrl_if.sv | 18 +
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder sequencer.
// The master supplies the start request and operands; the slave returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell walks the operands LSB-first,
// one bit per clock, then publishes sum/cout/ovf alongside a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | adding one bit per clock, cnt = current bit index
// DONE   | result published this cycle; a new start is accepted here too
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  // The single full-adder cell shared by every bit position.
  assign fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // On the MSB, carry_q is the carry into the MSB.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a latency/arithmetic model checked every
// cycle, plus directed operations pinned with hand-computed results.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   acc_cyc;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a result is plain a+b+cin, visible exactly WIDTH clocks after acceptance.
  function automatic logic [WIDTH+1:0] model_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic ci);
    logic [WIDTH:0] r;
    logic           v;
    r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return {v, r};
  endfunction

  int               m_rem;
  logic             m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [WIDTH-1:0] m_sum, p_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_sum  <= p_sum;
          m_cout <= p_cout;
          m_ovf  <= p_ovf;
        end
      end else if (bus.start) begin
        {p_ovf, p_cout, p_sum} <= model_add(bus.a, bus.b, bus.cin);
        m_rem <= WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 32'(bus.busy), 32'(m_rem != 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("sum",  32'(bus.sum),  32'(m_sum));
      chk("cout", 32'(bus.cout), 32'(m_cout));
      chk("ovf",  32'(bus.ovf),  32'(m_ovf));
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = ci;
    @(posedge clk); #2;
    acc_cyc   = cyc;
    bus.start = 1'b0;
    bus.a = ~x; bus.b = ~y; bus.cin = ~ci;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; break; end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(WIDTH));
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    start_op(x, y, ci);
    wait_done(name);
    chk({name, "_sum"},  32'(bus.sum),  32'(es));
    chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({name, "_ovf"},  32'(bus.ovf),  32'(eo));
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0; bus.start = 1'b0;

    run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Ignored start mid-run, then back-to-back start in the DONE cycle.
    start_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(posedge clk);
    #2 bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(posedge clk);
    #2 bus.start = 1'b0;
    wait_done("ign");
    chk("ign_sum", 32'(bus.sum), 32'h30);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    @(posedge clk); #2;
    acc_cyc = cyc; bus.start = 1'b0; bus.a = 8'hEE; bus.b = 8'hEE;
    @(negedge clk);
    chk("b2b_busy",      32'(bus.busy), 32'd1);
    chk("b2b_held_sum",  32'(bus.sum),  32'h30);
    repeat (3) @(negedge clk);
    chk("b2b_held_sum2", 32'(bus.sum),  32'h30);
    wait_done("b2b");
    chk("b2b_sum", 32'(bus.sum), 32'h02);

    // Reset in the middle of an operation.
    start_op(8'h01, 8'h02, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum",  32'(bus.sum),  32'd0);
    begin
      bit any_done = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.done) any_done = 1;
      end
      chk("abort_no_done", 32'(any_done), 32'd0);
    end
    run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
